// File: rtl/traffic_countdown_display_pkg.sv
// Shared phase encodings, legal lamp patterns and display constants for the
// traffic countdown display.
package traffic_pkg;

  typedef enum logic [1:0] {
    X1D2 = 2'b00,
    V1D2 = 2'b01,
    D1X2 = 2'b10,
    D1V2 = 2'b11
  } phase_t;

  localparam logic [5:0] LED_X1D2 = 6'b001_100;
  localparam logic [5:0] LED_V1D2 = 6'b010_100;
  localparam logic [5:0] LED_D1X2 = 6'b100_001;
  localparam logic [5:0] LED_D1V2 = 6'b100_010;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] MAX_SHOWN = 7'd99;

  typedef struct packed {
    logic   legal;
    phase_t phase;
  } led_dec_t;

  function automatic led_dec_t led_decode(input logic [5:0] led);
    led_dec_t d;
    d.legal = 1'b1;
    d.phase = X1D2;
    case (led)
      LED_X1D2: d.phase = X1D2;
      LED_V1D2: d.phase = V1D2;
      LED_D1X2: d.phase = D1X2;
      LED_D1V2: d.phase = D1V2;
      default:  d.legal = 1'b0;
    endcase
    return d;
  endfunction

  function automatic logic [6:0] clamp99(input logic [7:0] v);
    return (v > 8'd99) ? MAX_SHOWN : v[6:0];
  endfunction

endpackage

// File: rtl/traffic_countdown_display_if.sv
// Lamp/tick input from the light controller and the display pin bundle.
interface traffic_countdown_display_if;
  logic       tick;
  logic [5:0] led;
  logic [3:0] an;
  logic [6:0] seg;
  logic       err;

  modport master (
    output tick,
    output led,
    input  an,
    input  seg,
    input  err
  );

  modport slave (
    input  tick,
    input  led,
    output an,
    output seg,
    output err
  );
endinterface

// File: rtl/traffic_countdown_display_seg7_decode.sv
// BCD digit to active-low {g,f,e,d,c,b,a} segments; non-decimal codes and
// the blank request both turn every segment off.
module seg7_decode
  import traffic_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (bcd)
        4'd0:    seg = 7'h40;
        4'd1:    seg = 7'h79;
        4'd2:    seg = 7'h24;
        4'd3:    seg = 7'h30;
        4'd4:    seg = 7'h19;
        4'd5:    seg = 7'h12;
        4'd6:    seg = 7'h02;
        4'd7:    seg = 7'h78;
        4'd8:    seg = 7'h00;
        4'd9:    seg = 7'h10;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/traffic_countdown_display.sv
// Tracks seconds remaining per road from the lamp vector and 1 Hz tick and
// drives a 4-digit multiplexed 7-segment display (road 1 left, road 2 right).
//
//   phase | meaning
//   X1D2  | road 1 green,  road 2 red
//   V1D2  | road 1 yellow, road 2 red
//   D1X2  | road 1 red,    road 2 green
//   D1V2  | road 1 red,    road 2 yellow
module traffic_countdown_display
  import traffic_pkg::*;
#(
  parameter int T_G1     = 30,
  parameter int T_Y1     = 4,
  parameter int T_G2     = 20,
  parameter int T_Y2     = 4,
  parameter int SCAN_DIV = 50000
) (
  input logic                        clk,
  input logic                        rst,
  traffic_countdown_display_if.slave bus
);

  led_dec_t    dec;
  logic [5:0]  led_q;
  logic        chg;
  logic [6:0]  dur;
  logic [6:0]  rem;

  logic [16:0] scan_cnt;
  logic        scan_tc;
  logic [1:0]  idx;

  logic [6:0]  val1;
  logic [6:0]  val2;
  logic [3:0]  tens1;
  logic [3:0]  ones1;
  logic [3:0]  tens2;
  logic [3:0]  ones2;
  logic [3:0]  dig;
  logic        dig_blank;
  logic [6:0]  seg_nxt;

  logic [3:0]  an_q;
  logic [6:0]  seg_q;
  logic        err_q;

  assign dec     = led_decode(bus.led);
  assign chg     = dec.legal && (bus.led != led_q);
  assign scan_tc = (scan_cnt == 17'(SCAN_DIV - 1));

  always_comb begin
    dur = 7'(T_G1);
    case (dec.phase)
      X1D2:    dur = 7'(T_G1);
      V1D2:    dur = 7'(T_Y1);
      D1X2:    dur = 7'(T_G2);
      D1V2:    dur = 7'(T_Y2);
      default: dur = 7'(T_G1);
    endcase
  end

  // The red road waits for the other road's remaining green plus its yellow.
  always_comb begin
    val1 = clamp99({1'b0, rem});
    val2 = clamp99({1'b0, rem});
    case (dec.phase)
      X1D2:    val2 = clamp99({1'b0, rem} + 8'(T_Y1));
      D1X2:    val1 = clamp99({1'b0, rem} + 8'(T_Y2));
      default: ;
    endcase
  end

  assign tens1 = 4'(val1 / 7'd10);
  assign ones1 = 4'(val1 % 7'd10);
  assign tens2 = 4'(val2 / 7'd10);
  assign ones2 = 4'(val2 % 7'd10);

  always_comb begin
    dig       = ones2;
    dig_blank = 1'b0;
    case (idx)
      2'd0: dig = ones2;
      2'd1: begin
        dig       = tens2;
        dig_blank = (tens2 == 4'd0);
      end
      2'd2: dig = ones1;
      default: begin
        dig       = tens1;
        dig_blank = (tens1 == 4'd0);
      end
    endcase
  end

  seg7_decode u_seg7 (
    .bcd   (dig),
    .blank (dig_blank || !dec.legal),
    .seg   (seg_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      led_q <= '0;
      rem   <= '0;
      err_q <= 1'b0;
    end else begin
      led_q <= bus.led;
      err_q <= !dec.legal;
      if (chg) begin
        rem <= dur;
      end else if (bus.tick && dec.legal && (rem != 7'd0)) begin
        rem <= rem - 7'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else if (scan_tc) begin
      scan_cnt <= '0;
      idx      <= idx + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + 17'd1;
    end
  end

  // Digit pins lag the index and value by one clock so an/seg switch together.
  always_ff @(posedge clk) begin
    if (rst) begin
      an_q  <= 4'hF;
      seg_q <= SEG_BLANK;
    end else if (dec.legal) begin
      an_q  <= ~(4'b0001 << idx);
      seg_q <= seg_nxt;
    end else begin
      an_q  <= 4'hF;
      seg_q <= SEG_BLANK;
    end
  end

  assign bus.an  = an_q;
  assign bus.seg = seg_q;
  assign bus.err = err_q;

endmodule

// File: tb/tb_traffic_countdown_display.sv
// Directed bench for traffic_countdown_display: phase table plus reset,
// illegal-pattern and mid-phase reset sequences, read back via the scanned pins.
module tb_traffic_countdown_display;
  import traffic_pkg::*;

  logic clk;
  logic rst;
  traffic_countdown_display_if bus_if ();

  traffic_countdown_display #(
    .T_G1(30), .T_Y1(4), .T_G2(20), .T_Y2(4), .SCAN_DIV(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [6:0] cap[4];
  int         bad_an;

  typedef struct {
    logic [5:0] led;
    bit         tick_on_chg;
    int         n_ticks;
    int         exp_r1;
    int         exp_r2;
  } vec_t;

  vec_t vecs[9];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0:       return 7'h40;
      1:       return 7'h79;
      2:       return 7'h24;
      3:       return 7'h30;
      4:       return 7'h19;
      5:       return 7'h12;
      6:       return 7'h02;
      7:       return 7'h78;
      8:       return 7'h00;
      9:       return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // One full scan of four 4-clock slots, keeping the last seg seen per digit.
  task automatic capture();
    for (int k = 0; k < 4; k++) cap[k] = 7'h55;
    bad_an = 0;
    for (int c = 0; c < 16; c++) begin
      step();
      case (bus_if.an)
        4'b1110: cap[0] = bus_if.seg;
        4'b1101: cap[1] = bus_if.seg;
        4'b1011: cap[2] = bus_if.seg;
        4'b0111: cap[3] = bus_if.seg;
        default: bad_an++;
      endcase
    end
  endtask

  task automatic check_display(input string tag, input int r1, input int r2);
    capture();
    check({tag, " an onehot"}, bad_an, 0);
    check({tag, " r1 tens"}, int'(cap[3]), int'((r1 / 10 == 0) ? 7'h7F : seg_of(r1 / 10)));
    check({tag, " r1 ones"}, int'(cap[2]), int'(seg_of(r1 % 10)));
    check({tag, " r2 tens"}, int'(cap[1]), int'((r2 / 10 == 0) ? 7'h7F : seg_of(r2 / 10)));
    check({tag, " r2 ones"}, int'(cap[0]), int'(seg_of(r2 % 10)));
  endtask

  initial begin
    vecs[0] = '{LED_X1D2, 1'b0, 0, 30, 34};
    vecs[1] = '{LED_X1D2, 1'b0, 25, 5, 9};
    vecs[2] = '{LED_V1D2, 1'b1, 0, 4, 4};
    vecs[3] = '{LED_V1D2, 1'b0, 5, 0, 0};
    vecs[4] = '{LED_D1X2, 1'b0, 0, 24, 20};
    vecs[5] = '{LED_D1X2, 1'b0, 7, 17, 13};
    vecs[6] = '{LED_D1V2, 1'b0, 0, 4, 4};
    vecs[7] = '{LED_D1V2, 1'b0, 1, 3, 3};
    vecs[8] = '{LED_X1D2, 1'b0, 3, 27, 31};

    rst         = 1'b1;
    bus_if.led  = 6'b000_000;
    bus_if.tick = 1'b0;
    repeat (3) step();
    check("reset an", int'(bus_if.an), 'hF);
    check("reset seg", int'(bus_if.seg), 'h7F);
    check("reset err", int'(bus_if.err), 0);

    // Release reset with the first legal pattern: digit 0 is driven at once.
    rst        = 1'b0;
    bus_if.led = LED_X1D2;
    step();
    check("scan E1", int'(bus_if.an), 'hE);
    repeat (4) step();
    check("scan E5", int'(bus_if.an), 'hD);
    repeat (4) step();
    check("scan E9", int'(bus_if.an), 'hB);
    repeat (4) step();
    check("scan E13", int'(bus_if.an), 'h7);
    repeat (4) step();
    check("scan E17", int'(bus_if.an), 'hE);

    for (int i = 0; i < 9; i++) begin
      bus_if.led  = vecs[i].led;
      bus_if.tick = vecs[i].tick_on_chg;
      step();
      bus_if.tick = 1'b0;
      step();
      for (int t = 0; t < vecs[i].n_ticks; t++) begin
        bus_if.tick = 1'b1;
        step();
        bus_if.tick = 1'b0;
        step();
      end
      check($sformatf("vec%0d err", i), int'(bus_if.err), 0);
      check_display($sformatf("vec%0d", i), vecs[i].exp_r1, vecs[i].exp_r2);
    end

    // Illegal pattern: blanked and flagged; ticks during it must not count.
    bus_if.led = 6'b111_111;
    step();
    check("illegal err E1", int'(bus_if.err), 1);
    check("illegal an E1", int'(bus_if.an), 'hF);
    for (int c = 0; c < 9; c++) begin
      bus_if.tick = (c % 3 == 0);
      step();
    end
    bus_if.tick = 1'b0;
    check("illegal err E10", int'(bus_if.err), 1);
    check("illegal an E10", int'(bus_if.an), 'hF);
    check("illegal seg E10", int'(bus_if.seg), 'h7F);
    bus_if.led = LED_X1D2;
    step();
    check("restore err", int'(bus_if.err), 0);
    check("restore an", int'(bus_if.an == 4'hF), 0);
    check_display("restore", 30, 34);

    // Reset mid road-2 green with a coincident tick.
    bus_if.led = LED_D1X2;
    repeat (3) step();
    rst         = 1'b1;
    bus_if.tick = 1'b1;
    step();
    check("midrst an", int'(bus_if.an), 'hF);
    check("midrst seg", int'(bus_if.seg), 'h7F);
    check("midrst err", int'(bus_if.err), 0);
    rst         = 1'b0;
    bus_if.tick = 1'b0;
    step();
    check("midrst release an", int'(bus_if.an), 'hE);
    step();
    check_display("midrst", 24, 20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
